// File: rtl/s1_seq_pkg.sv
// Shared types and constants for the s1 cell-bank sequencer.
package s1_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CFG_W  = 7;
    localparam int SEL_A0 = 0;
    localparam int SEL_A1 = 1;
    localparam int SEL_B1 = 2;

    typedef struct packed {
        logic [2:0] sel;   // {B1,A1,A0}
        logic [3:0] d;
    } cell_cfg_t;

    // Counter must hold the larger phase length minus one; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/s1_seq_cfg_bank.sv
// Per-cell configuration register file with flattened cell_* outputs and
// out-of-range write detection.
module s1_seq_cfg_bank
    import s1_seq_pkg::*;
#(
    parameter int NCELL = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  cell_cfg_t            wr_cfg,
    output logic                 cfg_err,
    output logic [4*NCELL-1:0]   cell_d,
    output logic [NCELL-1:0]     cell_a0,
    output logic [NCELL-1:0]     cell_a1,
    output logic [NCELL-1:0]     cell_b1
);

    logic oor;

    // When the index space exactly covers the bank, no index can be out of range.
    generate
        if ((2**IDXW) > NCELL) begin : g_oor
            assign oor = (wr_idx >= IDXW'(NCELL));
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cfg_err <= 1'b0;
        else      cfg_err <= wr_en & oor;
    end

    generate
        for (genvar i = 0; i < NCELL; i++) begin : g_cell
            logic [CFG_W-1:0] q;

            always_ff @(posedge clk or negedge clr) begin
                if (!clr)                                q <= '0;
                else if (wr_en && wr_idx == IDXW'(i))    q <= wr_cfg;
            end

            assign cell_d[4*i +: 4] = q[3:0];
            assign cell_a0[i]       = q[4+SEL_A0];
            assign cell_a1[i]       = q[4+SEL_A1];
            assign cell_b1[i]       = q[4+SEL_B1];
        end
    endgenerate

endmodule

// File: rtl/s1_seq.sv
// Sequencer for a bank of s1 cells: clear, evaluate for a fixed number of
// clocks, then capture every cell output into result.
module s1_seq
    import s1_seq_pkg::*;
#(
    parameter int   NCELL           = 8,
    parameter int   IDXW            = 3,
    parameter int   CLR_CYCLES      = 2,
    parameter int   EVAL_CYCLES     = 1,
    parameter logic CELL_CLR_ACTIVE = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDXW-1:0]      cfg_idx,
    input  logic [3:0]           cfg_d,
    input  logic [2:0]           cfg_sel,
    output logic                 cfg_err,
    input  logic                 start,
    output logic                 busy,
    output logic [4*NCELL-1:0]   cell_d,
    output logic [NCELL-1:0]     cell_a0,
    output logic [NCELL-1:0]     cell_a1,
    output logic [NCELL-1:0]     cell_b1,
    output logic [NCELL-1:0]     cell_clr,
    input  logic [NCELL-1:0]     cell_out,
    output logic [NCELL-1:0]     result,
    output logic                 result_valid
);

    localparam int CNTW = cnt_width(CLR_CYCLES, EVAL_CYCLES);

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            clr_q, clr_n;
    logic            capture;
    logic            wr_en;
    cell_cfg_t       wr_cfg;

    // Writes are only possible in IDLE, so the cell config is frozen during a run.
    assign wr_en  = cfg_valid & cfg_ready;
    assign wr_cfg = '{sel: cfg_sel, d: cfg_d};

    s1_seq_cfg_bank #(
        .NCELL (NCELL),
        .IDXW  (IDXW)
    ) u_cfg_bank (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_idx  (cfg_idx),
        .wr_cfg  (wr_cfg),
        .cfg_err (cfg_err),
        .cell_d  (cell_d),
        .cell_a0 (cell_a0),
        .cell_a1 (cell_a1),
        .cell_b1 (cell_b1)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            cnt    <= '0;
            clr_q  <= CELL_CLR_ACTIVE;
            result <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            clr_q <= clr_n;
            if (capture) result <= cell_out;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    cnt_n   = CNTW'(CLR_CYCLES - 1);
                end
            end
            CLEAR: begin
                if (cnt == '0) begin
                    state_n = EVAL;
                    cnt_n   = CNTW'(EVAL_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            EVAL: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Registered from next state so cells stay cleared through system reset.
        clr_n = (state_n == CLEAR) ? CELL_CLR_ACTIVE : ~CELL_CLR_ACTIVE;
    end

    assign cfg_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign cell_clr     = {NCELL{clr_q}};

endmodule
